// File: rtl/serial_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_logic_pkg
// Description : Shared opcode constants and FSM state type for the bit-serial
//               bitwise logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_logic_pkg;

    // Opcode encoding shared with the parallel bitwise blocks
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Control FSM states; encoding 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_logic_unit_bit_op_cell.sv
`default_nettype none
// ============================================================================
// Module      : bit_op_cell
// Description : One-bit bitwise function f(a_bit, b_bit, op) built from gate
//               primitives, selected by the shared opcode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_op_cell
    import serial_logic_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic [1:0] op,
    output logic       f
);

    wire w_and;
    wire w_or;
    wire w_xor;
    wire w_nand;

    and  u_and  (w_and,  a_bit, b_bit);
    or   u_or   (w_or,   a_bit, b_bit);
    xor  u_xor  (w_xor,  a_bit, b_bit);
    nand u_nand (w_nand, a_bit, b_bit);

    // Select the gate output matching the opcode
    always_comb begin
        f = w_and;
        case (op)
            OP_AND:  f = w_and;
            OP_OR:   f = w_or;
            OP_XOR:  f = w_xor;
            OP_NAND: f = w_nand;
            default: f = w_and;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_logic_unit
// Description : Bit-serial AND/OR/XOR/NAND unit. Operands are accepted over a
//               valid/ready handshake, processed LSB first one bit per clock,
//               and the result is returned over a second handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_logic_unit
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state_q,  w_state_d;
    logic [WIDTH-1:0] r_sa_q,     w_sa_d;
    logic [WIDTH-1:0] r_sb_q,     w_sb_d;
    logic [1:0]       r_sop_q,    w_sop_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0] r_result_q, w_result_d;
    logic             w_bit;

    // Function of the current LSBs of the operand shift registers
    bit_op_cell u_cell (
        .a_bit (r_sa_q[0]),
        .b_bit (r_sb_q[0]),
        .op    (r_sop_q),
        .f     (w_bit)
    );

    // State, datapath and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_sa_q     <= '0;
            r_sb_q     <= '0;
            r_sop_q    <= OP_AND;
            r_cnt_q    <= '0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_sa_q     <= w_sa_d;
            r_sb_q     <= w_sb_d;
            r_sop_q    <= w_sop_d;
            r_cnt_q    <= w_cnt_d;
            r_result_q <= w_result_d;
        end
    end

    // Next-state and datapath update; result fills from the MSB end so that
    // after WIDTH shifts bit i lines up with operand bit i
    always_comb begin
        w_state_d  = r_state_q;
        w_sa_d     = r_sa_q;
        w_sb_d     = r_sb_q;
        w_sop_d    = r_sop_q;
        w_cnt_d    = r_cnt_q;
        w_result_d = r_result_q;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_sa_d     = a;
                    w_sb_d     = b;
                    w_sop_d    = op;
                    w_cnt_d    = '0;
                    w_result_d = '0;
                    w_state_d  = RUN;
                end
            end
            RUN: begin
                w_result_d = {w_bit, r_result_q[WIDTH-1:1]};
                w_sa_d     = r_sa_q >> 1;
                w_sb_d     = r_sb_q >> 1;
                w_cnt_d    = r_cnt_q + 1'b1;
                if (r_cnt_q == C_LAST) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state_q == IDLE);
    assign out_valid = (r_state_q == DONE);
    assign busy      = (r_state_q == RUN) || (r_state_q == DONE);
    assign result    = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_logic_unit
// Description : Self-checking bench for serial_logic_unit: a transaction-level
//               model predicts handshake outputs and result every cycle, and
//               directed vectors pin literal results and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_logic_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_logic_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [WIDTH-1:0] func(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Transaction model: an accepted operation is busy for WIDTH edges, then
    // its full result is offered until the consumer takes it
    logic             m_init  = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_clean = 1'b0;
    int               m_left  = 0;
    logic [WIDTH-1:0] m_f     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init  = 1'b1;
            m_done  = 1'b0;
            m_left  = 0;
            m_clean = 1'b1;
            m_f     = '0;
        end else if (m_init) begin
            if (m_done) begin
                if (out_ready) m_done = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (in_valid) begin
                m_f     = func(a, b, op);
                m_left  = WIDTH;
                m_clean = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (m_init) begin
            logic [2*WIDTH-1:0] wide;
            int n;
            chk("in_ready",  {31'b0, in_ready},  {31'b0, (!m_done && m_left == 0)});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_done});
            chk("busy",      {31'b0, busy},      {31'b0, (m_done || m_left > 0)});
            if (m_done) begin
                chk("result_done", {16'b0, result}, {16'b0, m_f});
            end else if (m_left > 0) begin
                // after n processed bits the low n result bits sit at the top
                n    = WIDTH - m_left;
                wide = {{WIDTH{1'b0}}, m_f} << (WIDTH - n);
                chk("result_partial", {16'b0, result}, {16'b0, wide[WIDTH-1:0]});
            end else if (m_clean) begin
                chk("result_reset", {16'b0, result}, 32'h0);
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic [1:0] top, input logic [WIDTH-1:0] expv,
                          input bit scramble, input bit bp);
        int edges;
        @(posedge clk); #1;
        chk("idle_ready", {31'b0, in_ready}, 32'h1);
        a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = !bp;
        @(posedge clk); #1;                    // acceptance edge
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            if (scramble) begin
                a  = WIDTH'($urandom);
                b  = WIDTH'($urandom);
                op = 2'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        // out_valid follows WIDTH+1 edges counting the acceptance edge
        chk("latency_edges", edges, WIDTH + 1);
        chk("result_literal", {16'b0, result}, {16'b0, expv});
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                if (i == 1) begin
                    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 2'b01;
                end else if (i == 2) begin
                    in_valid = 1'b0;
                end
                @(posedge clk); #1;
                chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
                chk("bp_in_ready",  {31'b0, in_ready},  32'h0);
                chk("bp_result",    {16'b0, result},    {16'b0, expv});
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;                    // handshake edge
        chk("ret_in_ready",  {31'b0, in_ready},  32'h1);
        chk("ret_out_valid", {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        chk("rst_result",    {16'b0, result},    32'h0);
        rst = 1'b0;

        run_op(16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0, 1'b0);
        run_op(16'h1234, 16'h4321, 2'b01, 16'h5335, 1'b0, 1'b0);
        run_op(16'hAAAA, 16'hFFFF, 2'b10, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0F0F, 2'b11, 16'hF0F0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h00FF, 2'b00, 16'h0034, 1'b0, 1'b1);
        run_op(16'hDEAD, 16'hBEEF, 2'b10, 16'h6042, 1'b1, 1'b0);

        // Abort an XOR after 7 RUN edges with a mid-cycle reset
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0F0F; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
        chk("abort_busy",      {31'b0, busy},      32'h0);
        chk("abort_in_ready",  {31'b0, in_ready},  32'h1);
        chk("abort_result",    {16'b0, result},    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("abort_no_output", {31'b0, out_valid}, 32'h0);
        end

        run_op(16'hFFFF, 16'h8001, 2'b00, 16'h8001, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_logic_unit.md
# serial_logic_unit

Bit-serial bitwise logic unit for the ALU datapath: accepts two 16-bit operands and an opcode over a valid/ready handshake. It computes AND, OR, XOR or NAND one bit per clock, LSB first, and returns the 16-bit result over a second valid/ready handshake. It is the area-lean, multi-cycle counterpart to the parallel bitwise gate arrays and sits between the operand register file and the ALU result mux.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  unit can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NAND
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result register
- busy  output  1  high in RUN or DONE

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: serial computation.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid && in_ready:
  - Latch a, b and op into shift registers sa, sb and register sop.
  - Clear bit counter cnt (width $clog2(WIDTH)) and result.
- RUN, each edge:
  - Compute f(sa[0], sb[0], sop).
  - Shift result right one place and insert the computed bit at result[WIDTH-1].
  - Shift sa and sb right.
  - cnt increments. When cnt == WIDTH-1 on this edge, go to DONE.
- After WIDTH RUN edges, result[i] = f(a[i], b[i]) for every i, with no bit reversal.
- DONE: hold result and out_valid steady until out_valid && out_ready, then go to IDLE. Hold indefinitely under backpressure.
- in_valid outside IDLE is ignored; a, b and op changes during RUN/DONE have no effect.
- result is only meaningful while out_valid=1; partial values are visible during RUN.
- Reset (any state, any time): state=IDLE, result=0, out_valid=0, busy=0, in_ready=1, cnt=0, sa=sb=0, sop=00. An in-flight operation is discarded and produces no output.
- Illegal/unreachable state encoding returns to IDLE on the next edge.

## Timing
- Acceptance on edge k; bits processed on edges k+1 … k+WIDTH; out_valid first high after edge k+WIDTH.
- Latency: WIDTH+1 clock edges from acceptance to out_valid (17 at default).
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high: accept, WIDTH RUN edges, DONE handshake edge, then back in IDLE.
- in_ready is not asserted in the same cycle as out_valid, so there is no pass-through or overlap.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Structure
- Shared package serial_logic_pkg:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11
  - state enum {IDLE, RUN, DONE}
- Sub-module bit_op_cell: 1-bit combinational f(a_bit, b_bit, op) built from gate primitives, consistent with the existing bitwise blocks.
- Top level holds the FSM, counter and shift registers.

## Test plan
- Reset: assert rst mid-cycle → immediately out_valid=0, result=16'h0000, busy=0, in_ready=1.
- AND: a=16'hF0F0, b=16'hFF00, op=00, out_ready=1 → out_valid high exactly 17 edges after acceptance, result=16'hF000, in_ready back high one edge after the handshake.
- All ops back-to-back:
  - OR 16'h1234|16'h4321 → 16'h5335
  - XOR 16'hAAAA^16'hFFFF → 16'h5555
  - NAND 16'hFFFF,16'h0F0F → 16'hF0F0
- Backpressure: out_ready low for 5 cycles after out_valid → result and out_valid stable, in_ready=0, and an in_valid pulse with new operands is ignored. Raising out_ready completes the handshake.
- Input isolation: change a, b and op every cycle during RUN → result equals the function of the operands latched at acceptance.
- Reset mid-op: assert rst after 7 RUN edges of XOR 16'h00FF^16'h0F0F → out_valid never asserts. After release, AND 16'hFFFF&16'h8001 yields 16'h8001 with normal 17-edge latency.
